grid_window_reader: RTL and testbench

- Read side of the gridding accumulate path; the counterpart of the write-back merge stage.
- Accepts a request with a grid sample address. Issues a double-word BRAM read. Extracts the PARALLELISM-sample window that starts at the sub-word offset. Delivers the window to the adder datapath through a valid/ready interface.
- Uses credit-based flow control and an internal output FIFO, so BRAM read latency never drops data under back-pressure.

---
 rtl/grid_window_reader_if.sv | 46 ++++
 rtl/grid_window_reader.sv | 88 ++++++++
 tb/tb_grid_window_reader.sv | 224 ++++++++++++++++++++++
 3 files changed

// File: rtl/grid_window_reader_if.sv
// grid_window_reader_if: request, BRAM read and window output signals of grid_window_reader.
// The win_raw signal exists only when WINDOW_RAW_OUT_EN is defined.
interface grid_window_reader_if #(
    parameter int COMPLEX = 2,
    parameter int PRECISION = 32,
    parameter int PARALLELISM = 15,
    parameter int BRAM_PARALLELISM_BITS = 4,
    parameter int BRAM_DEPTH_BITS = 10
);
    localparam int DATA_WIDTH = PRECISION * COMPLEX;
    localparam int DATA_PATH_WIDTH = PARALLELISM * DATA_WIDTH;
    localparam int BRAM_WIDTH = (2 ** BRAM_PARALLELISM_BITS) * DATA_WIDTH;
    localparam int AW = BRAM_DEPTH_BITS + BRAM_PARALLELISM_BITS;

    logic req_valid;
    logic req_ready;
    logic [AW-1:0] req_addr;
    logic bram_en;
    logic [BRAM_DEPTH_BITS-1:0] bram_addr;
    logic [BRAM_WIDTH*2-1:0] bram_dout;
    logic win_valid;
    logic win_ready;
    logic [DATA_PATH_WIDTH-1:0] win_data;
    logic [AW-1:0] win_addr;
`ifdef WINDOW_RAW_OUT_EN
    logic [BRAM_WIDTH*2-1:0] win_raw;

    modport master (
        input  req_valid, req_addr, bram_dout, win_ready,
        output req_ready, bram_en, bram_addr, win_valid, win_data, win_addr, win_raw
    );
    modport slave (
        output req_valid, req_addr, bram_dout, win_ready,
        input  req_ready, bram_en, bram_addr, win_valid, win_data, win_addr, win_raw
    );
`else
    modport master (
        input  req_valid, req_addr, bram_dout, win_ready,
        output req_ready, bram_en, bram_addr, win_valid, win_data, win_addr
    );
    modport slave (
        output req_valid, req_addr, bram_dout, win_ready,
        input  req_ready, bram_en, bram_addr, win_valid, win_data, win_addr
    );
`endif
endinterface

// File: rtl/grid_window_reader.sv
// grid_window_reader: double-word BRAM read, PARALLELISM-sample window extraction, FWFT output FIFO.
// Define WINDOW_RAW_OUT_EN to also store and deliver the full captured bram_dout on win_raw.
module grid_window_reader #(
    parameter int COMPLEX = 2,
    parameter int PRECISION = 32,
    parameter int PARALLELISM = 15,
    parameter int BRAM_PARALLELISM_BITS = 4,
    parameter int BRAM_DEPTH_BITS = 10,
    parameter int BRAM_LATENCY = 2,
    parameter int FIFO_DEPTH = 4
) (
    input logic clk,
    input logic rst_n,
    grid_window_reader_if.master bus
);
    localparam int DATA_WIDTH = PRECISION * COMPLEX;
    localparam int DATA_PATH_WIDTH = PARALLELISM * DATA_WIDTH;
    localparam int BRAM_WIDTH = (2 ** BRAM_PARALLELISM_BITS) * DATA_WIDTH;
    localparam int AW = BRAM_DEPTH_BITS + BRAM_PARALLELISM_BITS;
    localparam int L = BRAM_LATENCY;
    localparam int PW = $clog2(FIFO_DEPTH);
    localparam int CW = $clog2(FIFO_DEPTH + 1);
    localparam logic [CW:0] DEPTH_V = (CW + 1)'(FIFO_DEPTH);

    logic [L:0] vld;
    logic [AW-1:0] paddr [0:L];
    logic [BRAM_DEPTH_BITS-1:0] bram_addr_q;
    logic [CW-1:0] count;
    logic [PW-1:0] wr_ptr, rd_ptr;
    logic [DATA_PATH_WIDTH-1:0] mem_data [0:FIFO_DEPTH-1];
    logic [AW-1:0] mem_addr [0:FIFO_DEPTH-1];
    logic [CW:0] inflight;
    logic accept, push, pop;
    logic [BRAM_PARALLELISM_BITS-1:0] off;

    // Stage 0 is the issue register (aligned with bram_en); stage L lines up with bram_dout.
    always_comb begin
        inflight = '0;
        for (int i = 0; i <= L; i++) inflight = inflight + (CW + 1)'(vld[i]);
    end

    // Credits cover the issue stage, the latency pipe and the FIFO, so a stalled consumer can never overflow it.
    assign bus.req_ready = rst_n && ((CW + 1)'(count) + inflight < DEPTH_V);
    assign accept = bus.req_valid && bus.req_ready;
    assign push = vld[L];
    assign pop = bus.win_valid && bus.win_ready;
    assign off = paddr[L][BRAM_PARALLELISM_BITS-1:0];
    assign bus.bram_en = vld[0];
    assign bus.bram_addr = bram_addr_q;
    assign bus.win_valid = count != '0;
    assign bus.win_data = bus.win_valid ? mem_data[rd_ptr] : '0;
    assign bus.win_addr = bus.win_valid ? mem_addr[rd_ptr] : '0;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            vld <= '0;
            bram_addr_q <= '0;
            count <= '0;
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            vld <= {vld[L-1:0], accept};
            if (accept) bram_addr_q <= bus.req_addr[AW-1 -: BRAM_DEPTH_BITS];
            if (push) wr_ptr <= wr_ptr + 1'b1;
            if (pop) rd_ptr <= rd_ptr + 1'b1;
            count <= count + CW'(push) - CW'(pop);
        end
    end

    always_ff @(posedge clk) begin
        paddr[0] <= bus.req_addr;
        for (int i = 1; i <= L; i++) paddr[i] <= paddr[i-1];
        if (push) begin
            mem_data[wr_ptr] <= bus.bram_dout[off * DATA_WIDTH +: DATA_PATH_WIDTH];
            mem_addr[wr_ptr] <= paddr[L];
        end
    end

`ifdef WINDOW_RAW_OUT_EN
    logic [BRAM_WIDTH*2-1:0] mem_raw [0:FIFO_DEPTH-1];

    assign bus.win_raw = bus.win_valid ? mem_raw[rd_ptr] : '0;

    always_ff @(posedge clk) begin
        if (push) mem_raw[wr_ptr] <= bus.bram_dout;
    end
`endif
endmodule

// File: tb/tb_grid_window_reader.sv
// tb_grid_window_reader: directed bench for grid_window_reader with a latency-2 BRAM model and an in-order scoreboard.
module tb_grid_window_reader;
    logic clk = 1'b0;
    logic rst_n;
    int checks = 0, errors = 0, accepted = 0, delivered = 0, dropped = 0;
    logic [13:0] q[$];
    logic [1:0] en_d = '0;
    logic [9:0] a_d [0:1];
    logic [2047:0] dout;

    grid_window_reader_if bus ();

    grid_window_reader dut (.clk(clk), .rst_n(rst_n), .bus(bus));

    always #5 clk = ~clk;

    function automatic logic [63:0] smp(input logic [9:0] w, input int k);
        return {6'b0, w, 16'(k), 16'h0, 8'(k), 8'h00};
    endfunction

    function automatic logic [959:0] win(input logic [13:0] a);
        logic [959:0] r;
        for (int j = 0; j < 15; j++) r[j*64 +: 64] = smp(a[13:4], int'(a[3:0]) + j);
        return r;
    endfunction

    function automatic logic [13:0] addr_of(input logic [9:0] w, input int k);
        return {w + 10'(k), 4'(k * 3 + 1)};
    endfunction

    // BRAM model: data appears two cycles after bram_en, garbage otherwise.
    always @(posedge clk) begin
        en_d <= {en_d[0], bus.bram_en};
        a_d[0] <= bus.bram_addr;
        a_d[1] <= a_d[0];
    end

    always_comb begin
        dout = '1;
        if (en_d[1]) for (int k = 0; k < 32; k++) dout[k*64 +: 64] = smp(a_d[1], k);
    end

    assign bus.bram_dout = dout;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s obs=%0h exp=%0h", tag, obs, exp);
        end
    endtask

    task automatic chk_win(input string tag, input logic [959:0] o, input logic [959:0] e);
        int j = 0;
        checks++;
        assert (o === e) else begin
            while (j < 14 && o[j*64 +: 64] === e[j*64 +: 64]) j++;
            errors++;
            $error("FAIL %s sample %0d obs=%h exp=%h", tag, j, o[j*64 +: 64], e[j*64 +: 64]);
        end
    endtask

    always @(negedge clk) begin
        if (!rst_n) begin
            dropped += q.size();
            q.delete();
        end else begin
            if (bus.win_valid && bus.win_ready) begin
                if (q.size() == 0) chk("unexpected_window", 64'(q.size()), 64'd1);
                else begin
                    logic [13:0] e;
                    e = q.pop_front();
                    chk("win_addr_order", 64'(bus.win_addr), 64'(e));
                    chk_win("win_data_order", bus.win_data, win(e));
                    delivered++;
                end
            end
            if (bus.req_valid && bus.req_ready) begin
                q.push_back(bus.req_addr);
                accepted++;
            end
            chk("outstanding_le_depth", 64'(q.size() <= 4), 64'd1);
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic send(input logic [13:0] a);
        int n = 0;
        bus.req_valid = 1'b1;
        bus.req_addr = a;
        while (!bus.req_ready && n < 50) begin
            tick();
            n++;
        end
        chk("send_timeout", 64'(n < 50), 64'd1);
        tick();
        bus.req_valid = 1'b0;
    endtask

    task automatic drain();
        int n = 0;
        bus.win_ready = 1'b1;
        while ((q.size() != 0 || bus.win_valid) && n < 100) begin
            tick();
            n++;
        end
        chk("drain_timeout", 64'(n < 100), 64'd1);
    endtask

    task automatic single(input logic [13:0] a);
        bus.req_valid = 1'b1;
        bus.req_addr = a;
        chk("single_ready", 64'(bus.req_ready), 64'd1);
        tick();
        bus.req_valid = 1'b0;
        chk("single_bram_en", 64'(bus.bram_en), 64'd1);
        chk("single_bram_addr", 64'(bus.bram_addr), 64'(a[13:4]));
        tick();
        tick();
        chk("single_early_valid", 64'(bus.win_valid), 64'd0);
        tick();
        chk("single_win_valid", 64'(bus.win_valid), 64'd1);
        chk_win("single_win_data", bus.win_data, win(a));
        chk("single_win_addr", 64'(bus.win_addr), 64'(a));
        tick();
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog timeout");
        $fatal(1, "watchdog");
    end

    initial begin
        int a0, d0, r0, n;
        rst_n = 1'b0;
        bus.req_valid = 1'b1;
        bus.req_addr = 14'h0040;
        bus.win_ready = 1'b1;
        repeat (3) begin
            tick();
            chk("rst_req_ready", 64'(bus.req_ready), 64'd0);
        end
        chk("rst_bram_en", 64'(bus.bram_en), 64'd0);
        chk("rst_bram_addr", 64'(bus.bram_addr), 64'd0);
        chk("rst_win_valid", 64'(bus.win_valid), 64'd0);
        chk("rst_win_addr", 64'(bus.win_addr), 64'd0);
        chk_win("rst_win_data", bus.win_data, '0);
        rst_n = 1'b1;
        bus.req_valid = 1'b0;
        tick();
        single(14'h0040);
        single(14'h004F);
        for (int i = 0; i < 8; i++) send({10'(16 + i), 4'(i)});
        drain();
        chk("b2b_delivered", 64'(delivered), 64'd10);
        // Back-pressure: only four requests fit while the consumer is stalled.
        bus.win_ready = 1'b0;
        a0 = accepted;
        bus.req_valid = 1'b1;
        for (int i = 0; i < 10; i++) begin
            bus.req_addr = addr_of(10'h200, accepted - a0);
            tick();
        end
        chk("bp_accepted", 64'(accepted - a0), 64'd4);
        repeat (3) begin
            chk("bp_ready_low", 64'(bus.req_ready), 64'd0);
            tick();
        end
        chk("bp_accepted_hold", 64'(accepted - a0), 64'd4);
        chk("bp_win_valid", 64'(bus.win_valid), 64'd1);
        bus.req_valid = 1'b0;
        bus.win_ready = 1'b1;
        d0 = delivered;
        n = 0;
        while (delivered - d0 < 4 && n < 20) begin
            tick();
            n++;
        end
        chk("bp_released", 64'(delivered - d0), 64'd4);
        tick();
        chk("bp_ready_again", 64'(bus.req_ready), 64'd1);
        send(14'h2ABC);
        drain();
        // Concurrent push/pop with the FIFO pre-loaded to three entries.
        bus.win_ready = 1'b0;
        for (int i = 0; i < 3; i++) send(addr_of(10'h300, i));
        repeat (4) tick();
        chk("pp_fill_valid", 64'(bus.win_valid), 64'd1);
        chk("pp_fill_ready", 64'(bus.req_ready), 64'd1);
        a0 = accepted;
        bus.req_valid = 1'b1;
        for (int i = 0; i < 20; i++) begin
            bus.win_ready = ~bus.win_ready;
            bus.req_addr = addr_of(10'h310, accepted - a0);
            tick();
        end
        bus.req_valid = 1'b0;
        drain();
        chk("pp_progress", 64'(accepted - a0 >= 6), 64'd1);
        // Reset with three requests in flight; late BRAM data must be ignored.
        r0 = dropped;
        send(14'h1230);
        send(14'h1241);
        send(14'h1252);
        rst_n = 1'b0;
        tick();
        rst_n = 1'b1;
        for (int i = 0; i < 6; i++) begin
            chk("midrst_no_valid", 64'(bus.win_valid), 64'd0);
            tick();
        end
        chk("midrst_dropped", 64'(dropped - r0), 64'd3);
        single(14'h3FF5);
        drain();
        chk("total_accounted", 64'(delivered + dropped), 64'(accepted));
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
